i2s_serializer: RTL and testbench

//  Downstream of the echo/effect stage: takes the processed left/right words
//  (BITSIZE, two's complement) and shifts them MSB-first onto the DAC data line
//  in standard I2S format, slaved to the codec's bclk/lrclk.

---
 rtl/i2s_serializer.sv | 118 +++++++++++
 tb/tb_i2s_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// i2s_serializer
//   Shifts a left/right sample pair MSB-first onto an I2S data line. The block
//   is slaved to the codec's bclk/lrclk. Both words are captured together at the
//   start of the left slot, so a frame never carries words from two frames.
// Ports
//   bclk        bit clock; all logic runs on its rising edge
//   rst_n       asynchronous active-low reset
//   lrclk       word select from codec (0 = left slot, 1 = right slot)
//   enable      1 = output audio, 0 = mute (sdata held 0)
//   left_in     left sample, two's complement, BITSIZE bits
//   right_in    right sample, two's complement, BITSIZE bits
//   sdata       serial data to DAC, MSB first
//   frame_start one-cycle pulse when a new L/R pair is latched
//   synced      set once the first left-slot boundary has been seen
module i2s_serializer #(
    parameter int BITSIZE = 24
) (
    input  logic               bclk,
    input  logic               rst_n,
    input  logic               lrclk,
    input  logic               enable,
    input  logic [BITSIZE-1:0] left_in,
    input  logic [BITSIZE-1:0] right_in,
    output logic               sdata,
    output logic               frame_start,
    output logic               synced
);

    localparam int CW = $clog2(BITSIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               lr_q, lr_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BITSIZE-1:0] hold_q, hold_d;
    logic [BITSIZE-1:0] shift_q, shift_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               synced_q, synced_d;

    logic fall, rise, data_bit;

    // Edges are detected against the previous bclk's lrclk, which yields the
    // one-bit I2S delay between word select and the MSB.
    assign fall = lr_q & ~lrclk;
    assign rise = ~lr_q & lrclk;

    always_comb begin
        state_d       = state_q;
        lr_d          = lrclk;
        bit_cnt_d     = bit_cnt_q;
        hold_d        = hold_q;
        shift_d       = shift_q;
        frame_start_d = 1'b0;
        synced_d      = synced_q;
        data_bit      = 1'b0;

        if (fall) begin
            // Start of frame from any state: latch both channels at once.
            // The MSB goes out now, so the shifter keeps only the remaining bits.
            state_d       = LEFT;
            hold_d        = right_in;
            shift_d       = {left_in[BITSIZE-2:0], 1'b0};
            frame_start_d = 1'b1;
            synced_d      = 1'b1;
            bit_cnt_d     = CW'(1);
            data_bit      = left_in[BITSIZE-1];
        end else if (rise && state_q == LEFT) begin
            state_d   = RIGHT;
            shift_d   = {hold_q[BITSIZE-2:0], 1'b0};
            bit_cnt_d = CW'(1);
            data_bit  = hold_q[BITSIZE-1];
        end else if (state_q != IDLE) begin
            // A rise seen in RIGHT falls through here and is ignored. Once the
            // whole word has gone out the count saturates and the slot pads with 0.
            if (bit_cnt_q < CW'(BITSIZE)) begin
                data_bit  = shift_q[BITSIZE-1];
                shift_d   = {shift_q[BITSIZE-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Mute gates only the output; framing keeps running underneath.
        sdata_d = data_bit & enable;
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lr_q          <= 1'b1;
            bit_cnt_q     <= '0;
            hold_q        <= '0;
            shift_q       <= '0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            synced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lr_q          <= lr_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            shift_q       <= shift_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            synced_q      <= synced_d;
        end
    end

    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign synced      = synced_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer
//   Drives lrclk slot by slot, collects the serial stream of each slot into a
//   word (first bit received = most significant) and compares it with the
//   sample the slot should carry, zero-padded or truncated to the slot length.
module tb_i2s_serializer;

    localparam int BW = 24;

    logic          bclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lrclk = 1'b1;
    logic          enable = 1'b1;
    logic [BW-1:0] left_in = '0;
    logic [BW-1:0] right_in = '0;
    logic          sdata, frame_start, synced;

    int checks = 0;
    int errors = 0;

    i2s_serializer #(.BITSIZE(BW)) dut (
        .bclk        (bclk),
        .rst_n       (rst_n),
        .lrclk       (lrclk),
        .enable      (enable),
        .left_in     (left_in),
        .right_in    (right_in),
        .sdata       (sdata),
        .frame_start (frame_start),
        .synced      (synced)
    );

    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // What a slot of len bits should carry for word w: the word MSB-first,
    // followed by zeros if the slot is long, or only its top bits if short.
    function automatic logic [63:0] exp_word(input logic [BW-1:0] w, input int len);
        logic [63:0] e;
        e = 64'(w);
        if (len >= BW) e = e << (len - BW);
        else           e = e >> (BW - len);
        return e;
    endfunction

    // Plays one slot of len bclk cycles with lrclk=lr. enable is low for slot
    // cycles [off_a, off_b); right_in becomes chg_val at cycle chg_at.
    task automatic play_slot(input logic lr, input int len, input int off_a,
                             input int off_b, input int chg_at,
                             input logic [BW-1:0] chg_val,
                             output logic [63:0] bits, output int fs_cnt,
                             output logic fs_first, output logic sync_last);
        bits = '0;
        fs_cnt = 0;
        fs_first = 1'b0;
        for (int j = 0; j < len; j++) begin
            lrclk  = lr;
            enable = !(j >= off_a && j < off_b);
            if (j == chg_at) right_in = chg_val;
            @(posedge bclk);
            #1;
            bits = {bits[62:0], sdata};
            if (frame_start === 1'b1) fs_cnt++;
            if (j == 0) fs_first = frame_start;
        end
        sync_last = synced;
        enable = 1'b1;
    endtask

    task automatic play(input logic lr, input int len, output logic [63:0] bits,
                        output int fs_cnt, output logic fs_first, output logic sync_last);
        play_slot(lr, len, 0, 0, -1, '0, bits, fs_cnt, fs_first, sync_last);
    endtask

    task automatic test_reset();
        logic [63:0] b;
        int fc;
        logic ff, sy;
        rst_n = 1'b0;
        lrclk = 1'b1;
        #12;
        checks++;
        if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b want 0", sdata); end
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced got %b want 0", synced); end
        @(negedge bclk);
        rst_n = 1'b1;
        // lrclk still high: nothing may come out before the first left slot
        play(1'b1, 8, b, fc, ff, sy);
        checks++;
        if (b !== 64'd0) begin errors++; $display("FAIL pre_sync_sdata got %h want 0", b); end
        checks++;
        if (sy !== 1'b0 || fc != 0) begin
            errors++; $display("FAIL pre_sync_flags got synced=%b fs=%0d want 0/0", sy, fc);
        end
    endtask

    task automatic test_basic();
        logic [63:0] b;
        int fc;
        logic ff, sy;
        logic [BW-1:0] l, r;
        for (int f = 0; f < 4; f++) begin
            l = (f == 0) ? 24'hA50F3C : BW'($urandom);
            r = (f == 0) ? 24'h800001 : BW'($urandom);
            left_in = l;
            right_in = r;
            play(1'b0, 32, b, fc, ff, sy);
            left_in = BW'($urandom);  // after the capture: must not matter
            checks++;
            if (b !== exp_word(l, 32)) begin errors++; $display("FAIL basic_left f%0d got %h want %h", f, b, exp_word(l, 32)); end
            checks++;
            if (fc != 1 || ff !== 1'b1) begin errors++; $display("FAIL basic_fs f%0d got cnt=%0d first=%b want 1/1", f, fc, ff); end
            checks++;
            if (sy !== 1'b1) begin errors++; $display("FAIL basic_synced f%0d got %b want 1", f, sy); end
            play(1'b1, 32, b, fc, ff, sy);
            checks++;
            if (b !== exp_word(r, 32)) begin errors++; $display("FAIL basic_right f%0d got %h want %h", f, b, exp_word(r, 32)); end
            checks++;
            if (fc != 0) begin errors++; $display("FAIL basic_fs_right f%0d got %0d want 0", f, fc); end
        end
    endtask

    task automatic test_hold();
        logic [63:0] b;
        int fc;
        logic ff, sy;
        logic [BW-1:0] l, l2, r1, r2;
        l = BW'($urandom);
        l2 = BW'($urandom);
        r1 = 24'h5A5A5A;
        r2 = 24'hC3C3C3;
        left_in = l;
        right_in = r1;
        play_slot(1'b0, 32, 0, 0, 7, r2, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(l, 32)) begin errors++; $display("FAIL hold_left got %h want %h", b, exp_word(l, 32)); end
        play(1'b1, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(r1, 32)) begin errors++; $display("FAIL hold_right_old got %h want %h", b, exp_word(r1, 32)); end
        left_in = l2;
        play(1'b0, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(l2, 32)) begin errors++; $display("FAIL hold_left2 got %h want %h", b, exp_word(l2, 32)); end
        play(1'b1, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(r2, 32)) begin errors++; $display("FAIL hold_right_new got %h want %h", b, exp_word(r2, 32)); end
    endtask

    task automatic test_slot_len();
        logic [63:0] b;
        int fc, len;
        logic ff, sy;
        logic [BW-1:0] l, r;
        for (int f = 0; f < 7; f++) begin
            len = (f < 2) ? 16 : (f == 2) ? BW : $urandom_range(8, 40);
            l = BW'($urandom);
            r = BW'($urandom);
            left_in = l;
            right_in = r;
            play(1'b0, len, b, fc, ff, sy);
            checks++;
            if (b !== exp_word(l, len)) begin errors++; $display("FAIL len%0d_left got %h want %h", len, b, exp_word(l, len)); end
            checks++;
            if (fc != 1 || ff !== 1'b1) begin errors++; $display("FAIL len%0d_fs got cnt=%0d first=%b want 1/1", len, fc, ff); end
            play(1'b1, len, b, fc, ff, sy);
            checks++;
            if (b !== exp_word(r, len)) begin errors++; $display("FAIL len%0d_right got %h want %h", len, b, exp_word(r, len)); end
        end
    endtask

    task automatic test_enable();
        logic [63:0] b, m;
        int fc;
        logic ff, sy;
        logic [BW-1:0] l, r;
        l = 24'hFFFFFF;
        r = BW'($urandom);
        left_in = l;
        right_in = r;
        m = '1;
        for (int j = 4; j < 12; j++) m[31 - j] = 1'b0;
        play_slot(1'b0, 32, 4, 12, -1, '0, b, fc, ff, sy);
        checks++;
        if (b !== (exp_word(l, 32) & m)) begin errors++; $display("FAIL mute_left got %h want %h", b, exp_word(l, 32) & m); end
        checks++;
        if (fc != 1 || ff !== 1'b1) begin errors++; $display("FAIL mute_fs got cnt=%0d first=%b want 1/1", fc, ff); end
        play(1'b1, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(r, 32)) begin errors++; $display("FAIL mute_right got %h want %h", b, exp_word(r, 32)); end
        l = BW'($urandom);
        left_in = l;
        play(1'b0, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(l, 32)) begin errors++; $display("FAIL unmute_left got %h want %h", b, exp_word(l, 32)); end
        play(1'b1, 32, b, fc, ff, sy);
    endtask

    task automatic test_reset_mid();
        logic [63:0] b;
        int fc;
        logic ff, sy;
        logic [BW-1:0] l, r;
        l = BW'($urandom);
        r = 24'hFFFFFF;
        left_in = l;
        right_in = r;
        play(1'b0, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(l, 32)) begin errors++; $display("FAIL rmid_left got %h want %h", b, exp_word(l, 32)); end
        play(1'b1, 10, b, fc, ff, sy);
        checks++;
        if (b !== 64'h3FF) begin errors++; $display("FAIL rmid_right_head got %h want 3ff", b); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sdata !== 1'b0 || synced !== 1'b0) begin
            errors++; $display("FAIL rmid_async got sdata=%b synced=%b want 0/0", sdata, synced);
        end
        @(negedge bclk);
        rst_n = 1'b1;
        play(1'b1, 22, b, fc, ff, sy);
        checks++;
        if (b !== 64'd0 || sy !== 1'b0 || fc != 0) begin
            errors++; $display("FAIL rmid_after got bits=%h synced=%b fs=%0d want 0/0/0", b, sy, fc);
        end
        l = BW'($urandom);
        r = BW'($urandom);
        left_in = l;
        right_in = r;
        play(1'b0, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(l, 32) || fc != 1 || sy !== 1'b1) begin
            errors++; $display("FAIL rmid_restart_left got %h fs=%0d synced=%b want %h 1 1", b, fc, sy, exp_word(l, 32));
        end
        play(1'b1, 32, b, fc, ff, sy);
        checks++;
        if (b !== exp_word(r, 32)) begin errors++; $display("FAIL rmid_restart_right got %h want %h", b, exp_word(r, 32)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_slot_len();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
